// File: rtl/recirc_active_ctrl_pkg.sv
// Shared PHY definitions for the link-activation controller.
// State encoding and COM/lock/loss defaults reused across the PHY.
package recirc_active_ctrl_pkg;

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_LOCKING = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_LOSS    = 2'd3;

  localparam int          DATA_W_DEF   = 32;
  localparam logic [31:0] COM_WORD_DEF = 32'hBCBCBCBC;
  localparam int          N_LOCK_DEF   = 4;
  localparam int          N_LOSS_DEF   = 16;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] lock;
    logic [7:0] idle;
    logic       loss;
  } fsm_nxt_t;

endpackage

// File: rtl/recirc_active_ctrl_if.sv
// Word stream into the activation controller and the active
// qualifier it hands back to the recirculator.
interface recirc_active_ctrl_if
  import recirc_active_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [DATA_W-1:0] data_input;
  logic              valid;
  logic              active;

  modport master (
    output data_input,
    output valid,
    input  active
  );

  modport slave (
    input  data_input,
    input  valid,
    output active
  );

endinterface

// File: rtl/recirc_active_ctrl_word_match.sv
// COM word comparator: raw match for the FSM plus a
// registered com_det pulse.
module recirc_active_ctrl_word_match
  import recirc_active_ctrl_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] COM_WORD = DATA_W'(COM_WORD_DEF)
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_input,
  input  logic              valid,
  output logic              com,
  output logic              com_det
);

  assign com = valid && (data_input == COM_WORD);

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      com_det <= 1'b0;
    end else begin
      com_det <= com;
    end
  end

endmodule

// File: rtl/recirc_active_ctrl.sv
// Link-activation controller: lock on N_LOCK consecutive COM
// words, drop after N_LOSS idle cycles, sticky loss flag.
module recirc_active_ctrl
  import recirc_active_ctrl_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] COM_WORD = DATA_W'(COM_WORD_DEF),
  parameter int                N_LOCK   = N_LOCK_DEF,
  parameter int                N_LOSS   = N_LOSS_DEF
) (
  input  logic                 clk_2f,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clr_err,
  recirc_active_ctrl_if.slave  bus,
  output logic                 com_det,
  output logic [1:0]           state,
  output logic [3:0]           lock_cnt,
  output logic                 err_loss
);

  localparam logic [3:0] LOCK_N = 4'(N_LOCK);
  localparam logic [7:0] LOSS_N = 8'(N_LOSS);

  logic       com;
  logic [7:0] idle_cnt;
  logic [3:0] lock_inc;
  logic [7:0] idle_inc;
  fsm_nxt_t   nxt;

  recirc_active_ctrl_word_match #(
    .DATA_W   (DATA_W),
    .COM_WORD (COM_WORD)
  ) u_word_match (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .data_input (bus.data_input),
    .valid      (bus.valid),
    .com        (com),
    .com_det    (com_det)
  );

  assign lock_inc = lock_cnt + 4'd1;
  assign idle_inc = idle_cnt + 8'd1;

  always_comb begin
    nxt.st   = state;
    nxt.lock = lock_cnt;
    nxt.idle = idle_cnt;
    nxt.loss = 1'b0;
    unique case (state)
      ST_SEARCH: begin
        if (com) begin
          nxt.lock = 4'd1;
          nxt.st   = (LOCK_N == 4'd1) ? ST_ACTIVE
                                      : ST_LOCKING;
        end else begin
          nxt.lock = 4'd0;
        end
      end
      ST_LOCKING: begin
        if (com) begin
          nxt.lock = lock_inc;
          if (lock_inc == LOCK_N) begin
            nxt.st = ST_ACTIVE;
          end
        end else if (bus.valid) begin
          nxt.st   = ST_SEARCH;
          nxt.lock = 4'd0;
        end
      end
      ST_ACTIVE: begin
        // COM words are plain data once active
        if (bus.valid) begin
          nxt.idle = 8'd0;
        end else if (idle_inc == LOSS_N) begin
          nxt.st   = ST_LOSS;
          nxt.lock = 4'd0;
          nxt.idle = 8'd0;
          nxt.loss = 1'b1;
        end else begin
          nxt.idle = idle_inc;
        end
      end
      ST_LOSS: begin
        nxt.st   = ST_SEARCH;
        nxt.lock = 4'd0;
        nxt.idle = 8'd0;
      end
    endcase
    if (!enable) begin
      nxt.st   = ST_SEARCH;
      nxt.lock = 4'd0;
      nxt.idle = 8'd0;
      nxt.loss = 1'b0;
    end
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state      <= ST_SEARCH;
      lock_cnt   <= 4'd0;
      idle_cnt   <= 8'd0;
      err_loss   <= 1'b0;
      bus.active <= 1'b0;
    end else begin
      state      <= nxt.st;
      lock_cnt   <= nxt.lock;
      idle_cnt   <= nxt.idle;
      err_loss   <= nxt.loss | (err_loss & ~clr_err);
      bus.active <= (nxt.st == ST_ACTIVE);
    end
  end

endmodule

// File: tb/tb_recirc_active_ctrl.sv
// Bench for recirc_active_ctrl: directed pins plus randomized
// traffic against a behavioural model, two parameter builds.
module tb_recirc_active_ctrl;
  import recirc_active_ctrl_pkg::*;

  localparam logic [31:0] COM = 32'hBCBCBCBC;

  logic        clk_2f = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        clr_err = 1'b0;
  logic [31:0] din = 32'h0;
  logic        vld = 1'b0;
  bit          chk_en = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk_2f = ~clk_2f;

  recirc_active_ctrl_if #(.DATA_W(32)) bus0 ();
  recirc_active_ctrl_if #(.DATA_W(32)) bus1 ();

  assign bus0.data_input = din;
  assign bus0.valid = vld;
  assign bus1.data_input = din;
  assign bus1.valid = vld;

  logic       act_o [2];
  logic       cdet_o [2];
  logic [1:0] st_o [2];
  logic [3:0] lock_o [2];
  logic       err_o [2];

  assign act_o[0] = bus0.active;
  assign act_o[1] = bus1.active;

  recirc_active_ctrl #(
    .DATA_W(32), .COM_WORD(COM), .N_LOCK(4), .N_LOSS(16)
  ) u_dut0 (
    .clk_2f(clk_2f), .reset(reset), .enable(enable),
    .clr_err(clr_err), .bus(bus0), .com_det(cdet_o[0]),
    .state(st_o[0]), .lock_cnt(lock_o[0]), .err_loss(err_o[0])
  );

  recirc_active_ctrl #(
    .DATA_W(32), .COM_WORD(COM), .N_LOCK(1), .N_LOSS(3)
  ) u_dut1 (
    .clk_2f(clk_2f), .reset(reset), .enable(enable),
    .clr_err(clr_err), .bus(bus1), .com_det(cdet_o[1]),
    .state(st_o[1]), .lock_cnt(lock_o[1]), .err_loss(err_o[1])
  );

  // behavioural model: run lengths of COM words and idle cycles
  int nl [2] = '{4, 1};
  int ns [2] = '{16, 3};
  int m_mode [2];
  int m_run [2];
  int m_idle [2];
  bit m_err [2];
  bit m_cdet [2];

  always @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0; m_run[i] = 0; m_idle[i] = 0;
        m_err[i] = 0; m_cdet[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit is_com;
        bit lost;
        is_com = vld && (din == COM);
        lost = 0;
        m_cdet[i] = is_com;
        if (!enable) begin
          m_mode[i] = 0; m_run[i] = 0; m_idle[i] = 0;
        end else if (m_mode[i] == 3) begin
          m_mode[i] = 0; m_run[i] = 0; m_idle[i] = 0;
        end else if (m_mode[i] == 2) begin
          m_idle[i] = vld ? 0 : m_idle[i] + 1;
          if (m_idle[i] == ns[i]) begin
            m_mode[i] = 3; m_run[i] = 0; m_idle[i] = 0;
            lost = 1;
          end
        end else if (is_com) begin
          m_run[i] = m_run[i] + 1;
          m_mode[i] = (m_run[i] >= nl[i]) ? 2 : 1;
        end else if (vld || m_mode[i] == 0) begin
          m_mode[i] = 0; m_run[i] = 0;
        end
        if (lost) m_err[i] = 1;
        else if (clr_err) m_err[i] = 0;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_2f) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("m_state%0d", i), int'(st_o[i]), m_mode[i]);
        chk($sformatf("m_active%0d", i), int'(act_o[i]),
            int'(m_mode[i] == 2));
        chk($sformatf("m_lock%0d", i), int'(lock_o[i]), m_run[i]);
        chk($sformatf("m_comdet%0d", i), int'(cdet_o[i]),
            int'(m_cdet[i]));
        chk($sformatf("m_err%0d", i), int'(err_o[i]), int'(m_err[i]));
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] d);
    vld = v;
    din = d;
    @(posedge clk_2f);
    @(negedge clk_2f);
  endtask

  int exp_st [4] = '{1, 1, 1, 2};
  int exp_act [4] = '{0, 0, 0, 1};

  initial begin
    @(negedge clk_2f);
    @(negedge clk_2f);
    reset = 1'b0;
    chk_en = 1'b1;

    // reach ACTIVE, then reset mid-stream
    repeat (4) step(1'b1, COM);
    chk("pre_active", int'(act_o[0]), 1);
    #3 reset = 1'b1;
    #1;
    chk("rst_active", int'(act_o[0]), 0);
    chk("rst_state", int'(st_o[0]), 0);
    chk("rst_lock", int'(lock_o[0]), 0);
    chk("rst_err", int'(err_o[0]), 0);
    @(negedge clk_2f);
    reset = 1'b0;
    step(1'b1, 32'h12345678);

    for (int k = 0; k < 4; k++) begin
      step(1'b1, COM);
      chk($sformatf("lock_st%0d", k), int'(st_o[0]), exp_st[k]);
      chk($sformatf("lock_act%0d", k), int'(act_o[0]), exp_act[k]);
      chk($sformatf("lock_cnt%0d", k), int'(lock_o[0]), k + 1);
      chk($sformatf("lock_cdet%0d", k), int'(cdet_o[0]), 1);
      if (k == 0) begin
        chk("nlock1_state", int'(st_o[1]), 2);
        chk("nlock1_active", int'(act_o[1]), 1);
      end
    end

    // idle run just short of loss, then a full loss
    repeat (15) step(1'b0, 32'h0);
    chk("idle15_state", int'(st_o[0]), 2);
    step(1'b1, 32'h0);
    repeat (15) step(1'b0, 32'h0);
    chk("idle_rst_state", int'(st_o[0]), 2);
    step(1'b0, 32'h0);
    chk("loss_state", int'(st_o[0]), 3);
    chk("loss_active", int'(act_o[0]), 0);
    chk("loss_err", int'(err_o[0]), 1);
    chk("loss_lock", int'(lock_o[0]), 0);
    step(1'b1, COM);
    chk("post_loss_state", int'(st_o[0]), 0);
    chk("post_loss_lock", int'(lock_o[0]), 0);

    // clear, then clear colliding with a new loss
    clr_err = 1'b1;
    step(1'b0, 32'h0);
    clr_err = 1'b0;
    chk("clr_err", int'(err_o[0]), 0);
    repeat (4) step(1'b1, COM);
    repeat (15) step(1'b0, 32'h0);
    clr_err = 1'b1;
    step(1'b0, 32'h0);
    clr_err = 1'b0;
    chk("set_wins_err", int'(err_o[0]), 1);
    chk("set_wins_state", int'(st_o[0]), 3);
    step(1'b0, 32'h0);

    // broken lock, then lock across idle gaps
    step(1'b1, COM);
    step(1'b1, COM);
    chk("brk_pre_lock", int'(lock_o[0]), 2);
    step(1'b1, 32'h12345678);
    chk("brk_state", int'(st_o[0]), 0);
    chk("brk_lock", int'(lock_o[0]), 0);
    step(1'b1, COM);
    step(1'b0, COM);
    step(1'b1, COM);
    step(1'b0, 32'h0);
    chk("gap_lock", int'(lock_o[0]), 2);
    chk("gap_state", int'(st_o[0]), 1);
    step(1'b1, COM);
    step(1'b1, COM);
    chk("gap_active", int'(act_o[0]), 1);
    chk("gap_lock4", int'(lock_o[0]), 4);

    // enable drop from ACTIVE
    enable = 1'b0;
    step(1'b1, COM);
    enable = 1'b1;
    chk("dis_state", int'(st_o[0]), 0);
    chk("dis_active", int'(act_o[0]), 0);
    chk("dis_err", int'(err_o[0]), 1);
    chk("dis_cdet", int'(cdet_o[0]), 1);
    repeat (3) step(1'b1, COM);
    chk("relock3_state", int'(st_o[0]), 1);
    step(1'b1, COM);
    chk("relock4_state", int'(st_o[0]), 2);

    // randomized bursty traffic
    for (int seg = 0; seg < 400; seg++) begin
      int kind;
      int len;
      kind = $urandom_range(0, 3);
      len = $urandom_range(1, 20);
      for (int c = 0; c < len; c++) begin
        logic        v;
        logic [31:0] d;
        enable = ($urandom_range(0, 49) != 0);
        clr_err = ($urandom_range(0, 19) == 0);
        d = $urandom;
        case (kind)
          0: v = 1'b0;
          1: begin v = 1'b1; d = COM; end
          2: v = 1'b1;
          default: begin
            v = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) d = COM;
          end
        endcase
        if ($urandom_range(0, 299) == 0) begin
          #1 reset = 1'b1;
          #2 reset = 1'b0;
        end
        step(v, d);
      end
    end

    enable = 1'b1;
    clr_err = 1'b0;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/recirc_active_ctrl.md
Name: recirc_active_ctrl

Overview:
- Link-activation controller that generates the `active` qualifier consumed by the recirculator stage on the clk_2f domain.
- Watches the same 32-bit word stream and its `valid` flag. Declares the lane active after N_LOCK consecutive valid COM words, and drops it after N_LOSS consecutive idle cycles.
- Reports its state and a sticky loss-of-link flag for the PHY status logic.

Parameters:
- DATA_W, 32, width of the data word.
- COM_WORD, 32'hBCBCBCBC, alignment word that counts toward lock.
- N_LOCK, 4, consecutive valid COM words required to go active (legal range 1..15).
- N_LOSS, 16, consecutive valid=0 cycles in ACTIVE that declare loss (legal range 2..255).

Ports:
- clk_2f  in  1  word clock, same as the recirculator.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  controller enable; 0 forces SEARCH.
- clr_err  in  1  clears the sticky err_loss flag.
- data_input  in  DATA_W  incoming word.
- valid  in  1  data_input qualifier.
- active  out  1  registered; drives the recirculator active input.
- com_det  out  1  registered one-cycle pulse: valid && data_input==COM_WORD.
- state  out  2  encoded FSM state: SEARCH=0, LOCKING=1, ACTIVE=2, LOSS=3.
- lock_cnt  out  4  current count of consecutive COM words.
- err_loss  out  1  sticky loss-of-link flag.

Behaviour:
- Reset (async, high)
  - state=SEARCH; active=0, com_det=0, lock_cnt=0, idle_cnt=0, err_loss=0.
  - Release is synchronous to the next clk_2f edge.
- Timing
  - All outputs are registered.
  - active reflects the state reached at the edge where the deciding word is sampled: 1 clk latency from that word.
  - active=1 exactly when state==ACTIVE.
- Match definition: com = valid && (data_input==COM_WORD). com_det <= com every cycle, regardless of state or enable.
- SEARCH
  - com: lock_cnt<=1; go to ACTIVE if N_LOCK==1, else go to LOCKING.
  - Otherwise stay in SEARCH with lock_cnt=0.
- LOCKING
  - com: lock_cnt+1; if lock_cnt+1==N_LOCK go to ACTIVE.
  - valid && !com: go to SEARCH, lock_cnt=0.
  - valid=0: hold state and lock_cnt (idle does not break lock acquisition).
- ACTIVE
  - valid=1: idle_cnt<=0. COM words are ordinary data here; lock_cnt holds at N_LOCK.
  - valid=0: idle_cnt+1; if idle_cnt+1==N_LOSS, go to LOSS and set err_loss=1.
  - No other exit except enable=0 or reset.
- LOSS
  - Lasts exactly one cycle with active=0, lock_cnt=0, idle_cnt=0, then SEARCH unconditionally.
  - A COM word sampled in LOSS is not counted.
- enable=0
  - Synchronous priority over all transitions: next state SEARCH, lock_cnt=0, idle_cnt=0.
  - err_loss is untouched; com_det still updates.
- err_loss
  - Set on the ACTIVE->LOSS transition; cleared by clr_err.
  - Set and clear in the same cycle: set wins.
- Widths
  - idle_cnt is 8 bits and lock_cnt is 4 bits.
  - Neither can wrap under the legal parameter ranges; compare with the +1 value so there is no off-by-one.
- Reset mid-ACTIVE: active drops asynchronously with reset assertion.

Decomposition:
- Shared PHY package holds:
  - state encoding constants (SEARCH/LOCKING/ACTIVE/LOSS);
  - COM_WORD default, 32'hBCBCBCBC;
  - N_LOCK/N_LOSS defaults.
  The transmitter side and the recirculator bench reuse them.
- One natural sub-module, word_match: a registered comparator producing com and com_det. Keep everything else in a single FSM and counter file.

Test Plan:
- Reset asserted mid-stream, then released; 4 words 0xBCBCBCBC with valid=1 -> active=0 through the 3rd word; active=1 the cycle after the 4th; state goes 1,1,1,2; com_det pulses 4 times.
- In LOCKING with lock_cnt=2, send valid word 0x12345678 -> state=SEARCH, lock_cnt=0. With a valid=0 gap between COM words instead -> lock_cnt holds and active is still reached after 4 COMs.
- ACTIVE, then 15 valid=0 cycles, then one valid=1 -> stays ACTIVE, idle_cnt resets. Then 16 valid=0 cycles -> state=LOSS for 1 cycle, active=0, err_loss=1, then SEARCH.
- err_loss=1; clr_err=1 for 1 cycle -> err_loss=0. Clear and a new loss in the same cycle -> err_loss stays 1.
- ACTIVE; enable=0 for 1 cycle -> next cycle state=SEARCH, active=0, err_loss unchanged. Re-lock requires 4 fresh COM words.
- N_LOCK=1 build: single COM word in SEARCH -> state=ACTIVE directly, active=1 one clk later.
